// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte (start, 8 data LSB first, odd parity,
// stop) over the open-drain ps2_clk/ps2_data lines and checks the device ACK bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  // state     | meaning
  // IDLE      | lines released, tx_ready=1
  // INHIBIT   | ps2_clk held low (request to send)
  // START     | both lines low, start bit presented
  // SEND      | device clocks out data, parity, stop
  // ACK       | waiting for falling edge 11 to sample the ACK bit
  // WAIT_IDLE | waiting for both lines to return high before reporting
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;

  localparam int MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_CYC = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    edge_cnt, edge_n;
  logic [9:0]    shreg, shreg_n;
  logic          ack_ok, ok_n;
  logic [2:0]    clk_sync, data_sync;
  logic          ready_n, busy_n, done_n, ack_err_n, to_err_n, clk_oe_n, data_oe_n;
  logic          fall, clk_lvl, data_lvl;

  assign fall     = (clk_sync[2:1] == 2'b10);
  assign clk_lvl  = clk_sync[1];
  assign data_lvl = data_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      edge_cnt    <= '0;
      shreg       <= '0;
      ack_ok      <= 1'b0;
      clk_sync    <= 3'b111;
      data_sync   <= 3'b111;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      edge_cnt    <= edge_n;
      shreg       <= shreg_n;
      ack_ok      <= ok_n;
      clk_sync    <= {clk_sync[1:0], ps2_clk_i};
      data_sync   <= {data_sync[1:0], ps2_data_i};
      tx_ready    <= ready_n;
      busy        <= busy_n;
      done        <= done_n;
      ack_err     <= ack_err_n;
      timeout_err <= to_err_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    edge_n    = edge_cnt;
    shreg_n   = shreg;
    ok_n      = ack_ok;
    ready_n   = tx_ready;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    to_err_n  = 1'b0;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n   = INHIBIT;
          cnt_n     = CW'(INHIBIT_CYCLES - 1);
          edge_n    = '0;
          shreg_n   = {1'b1, ~^tx_data, tx_data};
          ok_n      = 1'b0;
          ready_n   = 1'b0;
          busy_n    = 1'b1;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
        end
      end
      INHIBIT: begin
        if (cnt == '0) begin
          state_n   = START;
          cnt_n     = CW'(START_CYCLES - 1);
          data_oe_n = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n  = SEND;
          cnt_n    = CW'(TIMEOUT_CYCLES - 1);
          clk_oe_n = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SEND, ACK, WAIT_IDLE: begin
        if (cnt == '0) begin
          // timeout overrides any edge or idle condition seen in the same cycle
          state_n   = IDLE;
          to_err_n  = 1'b1;
          busy_n    = 1'b0;
          ready_n   = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
        end else begin
          cnt_n = fall ? CW'(TIMEOUT_CYCLES - 1) : cnt - CW'(1);
          if (fall && edge_cnt != 4'hF) edge_n = edge_cnt + 4'd1;
          if (state == SEND && fall) begin
            data_oe_n = ~shreg[0];
            shreg_n   = {1'b0, shreg[9:1]};
            if (edge_cnt == 4'd9) state_n = ACK;
          end else if (state == ACK && fall) begin
            ok_n    = ~data_lvl;
            state_n = WAIT_IDLE;
          end else if (state == WAIT_IDLE && clk_lvl && data_lvl) begin
            state_n   = IDLE;
            done_n    = ack_ok;
            ack_err_n = ~ack_ok;
            busy_n    = 1'b0;
            ready_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device clocking at 1/40 of clk.
module tb_ps2_host_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, ack_err, timeout_err;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, ack_cnt = 0, to_cnt = 0;

  assign ps2_clk_i  = ~(dev_clk_low | ps2_clk_oe);
  assign ps2_data_i = ~(dev_data_low | ps2_data_oe);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .START_CYCLES(4), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (ack_err) ack_cnt <= ack_cnt + 1;
    if (timeout_err) to_cnt <= to_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done || ack_err || timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Device side: waits for request-to-send, then generates clock pulses, sampling the data
  // line at the end of each high phase. Pulse 11 carries the ACK (low when ack_low).
  task automatic dev_frame(input int pulses, input bit ack_low, input int hold,
                           output logic [10:0] rx, output bit started);
    rx = '0;
    started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ps2_clk_i && !ps2_data_i) begin
        started = 1'b1;
        break;
      end
    end
    if (started) begin
      repeat (5) @(negedge clk);
      for (int p = 0; p < pulses; p++) begin
        repeat (20) @(negedge clk);
        if (p < 11) rx[p] = ps2_data_i;
        if (p == 10) dev_data_low = ack_low;
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
      end
      if (pulses >= 11) begin
        repeat (hold) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [10:0] rx;
    logic [7:0]  next_byte;
    bit          ok, seen;
    int          bd, ba, bt, n, early;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, ack_err, timeout_err}), 32'd0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 0xED with ACK
    bd = done_cnt; ba = ack_cnt; bt = to_cnt;
    offer(8'hED);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_low", 32'(tx_ready), 32'd0);
    dev_frame(11, 1'b1, 0, rx, ok);
    check("t1_started", 32'(ok), 32'd1);
    check("t1_frame", 32'(rx), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    wait_pulse(100, seen);
    check("t1_seen", 32'(seen), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_ready_back", 32'(tx_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("t1_done_cnt", 32'(done_cnt - bd), 32'd1);
    check("t1_err_cnt", 32'((ack_cnt - ba) + (to_cnt - bt)), 32'd0);
    check("t1_oe_after", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

    // 2: 0x00, device NAKs
    bd = done_cnt; ba = ack_cnt; bt = to_cnt;
    offer(8'h00);
    dev_frame(11, 1'b0, 0, rx, ok);
    check("t2_frame", 32'(rx), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
    wait_pulse(100, seen);
    check("t2_ack_err", 32'(ack_err), 32'd1);
    repeat (5) @(negedge clk);
    check("t2_ack_cnt", 32'(ack_cnt - ba), 32'd1);
    check("t2_done_cnt", 32'((done_cnt - bd) + (to_cnt - bt)), 32'd0);

    // 3: 0xF4, device silent
    bd = done_cnt; ba = ack_cnt; bt = to_cnt;
    offer(8'hF4);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin n++; @(negedge clk); end
    check("t3_inhibit_len", 32'(n), 32'd20);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 100) begin n++; @(negedge clk); end
    check("t3_start_len", 32'(n), 32'd4);
    n = 0;
    while (!timeout_err && n < 3000) begin n++; @(negedge clk); end
    check("t3_timeout_len", 32'(n), 32'd2000);
    check("t3_ready", 32'(tx_ready), 32'd1);
    check("t3_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    repeat (5) @(negedge clk);
    check("t3_to_cnt", 32'(to_cnt - bt), 32'd1);
    check("t3_other_cnt", 32'((done_cnt - bd) + (ack_cnt - ba)), 32'd0);

    // 4: reset mid-frame of 0xAA, then full 0xAA frame
    bd = done_cnt; ba = ack_cnt; bt = to_cnt;
    offer(8'hAA);
    dev_frame(5, 1'b1, 0, rx, ok);
    check("t4_partial", 32'(rx[4:0]), 32'(5'b10100));
    check("t4_data_oe_pre", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_oe_rst", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("t4_ready_rst", 32'(tx_ready), 32'd1);
    check("t4_busy_rst", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_no_pulses", 32'((done_cnt - bd) + (ack_cnt - ba) + (to_cnt - bt)), 32'd0);
    offer(8'hAA);
    dev_frame(11, 1'b1, 0, rx, ok);
    check("t4_frame", 32'(rx), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
    wait_pulse(100, seen);
    check("t4_done", 32'(done), 32'd1);

    // 5: tx_valid held with tx_data changing
    repeat (3) @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    check("t5_accept", 32'(busy), 32'd1);
    seen = 1'b0;
    early = 0;
    fork
      dev_frame(11, 1'b1, 0, rx, ok);
      begin
        for (int i = 0; i < 1500; i++) begin
          if (done) begin
            seen = 1'b1;
            break;
          end
          if (tx_ready) early++;
          tx_data = tx_data + 8'h1D;
          @(negedge clk);
        end
      end
    join
    check("t5_frame", 32'(rx), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    check("t5_done_seen", 32'(seen), 32'd1);
    check("t5_no_early_ready", 32'(early), 32'd0);
    check("t5_ready_at_done", 32'(tx_ready), 32'd1);
    next_byte = tx_data;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t5_reaccept_busy", 32'(busy), 32'd1);
    check("t5_reaccept_ready", 32'(tx_ready), 32'd0);
    dev_frame(11, 1'b1, 0, rx, ok);
    check("t5_frame2", 32'(rx), 32'({1'b1, ~^next_byte, next_byte, 1'b0}));
    wait_pulse(100, seen);
    check("t5_done2", 32'(done), 32'd1);

    // 6: device holds data low 100 cycles after ACK
    repeat (3) @(negedge clk);
    bd = done_cnt; ba = ack_cnt;
    offer(8'h55);
    dev_frame(11, 1'b1, 100, rx, ok);
    check("t6_frame", 32'(rx), 32'({1'b1, 1'b1, 8'h55, 1'b0}));
    @(negedge clk);
    check("t6_no_early_done", 32'(done_cnt - bd), 32'd0);
    check("t6_busy_held", 32'(busy), 32'd1);
    wait_pulse(50, seen);
    check("t6_done", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    check("t6_done_cnt", 32'(done_cnt - bd), 32'd1);
    check("t6_ack_cnt", 32'(ack_cnt - ba), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
